gray_conv_ctrl: RTL and testbench

GRAY_CONV_CTRL -- requirements
Module: gray_conv_ctrl

---
 rtl/gray_conv_ctrl_pkg.sv | 15 +
 rtl/gray_conv_ctrl_if.sv | 31 +++
 rtl/gray_conv_ctrl_px_coord_cnt.sv | 41 ++++
 rtl/gray_conv_ctrl.sv | 113 +++++++++++
 tb/tb_gray_conv_ctrl.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/gray_conv_ctrl_pkg.sv
// Shared types and constants for the gray conversion controller.
//   state_t : FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   COORD_W : width of the Col/Row coordinate outputs
package gray_conv_ctrl_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/gray_conv_ctrl_if.sv
// Handshake/status bundle between the frame controller and its environment.
//   start, pix_valid, out_ready        : driven by the environment (master)
//   pix_ready, load_en, pipe_en,
//   out_en, out_valid, col, row,
//   busy, frame_done                   : driven by the controller (slave)
interface gray_conv_ctrl_if;
  import gray_conv_ctrl_pkg::*;

  logic               start;
  logic               pix_valid;
  logic               pix_ready;
  logic               load_en;
  logic               pipe_en;
  logic               out_en;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic               busy;
  logic               frame_done;

  modport master (
    output start, pix_valid, out_ready,
    input  pix_ready, load_en, pipe_en, out_en, out_valid, col, row, busy, frame_done
  );

  modport slave (
    input  start, pix_valid, out_ready,
    output pix_ready, load_en, pipe_en, out_en, out_valid, col, row, busy, frame_done
  );
endinterface

// File: rtl/gray_conv_ctrl_px_coord_cnt.sv
// Column/row coordinate counter for the output side of the gray converter.
//   i_clk, i_clear_n : clock, synchronous active-low reset
//   i_clr            : synchronous clear (frame start)
//   i_adv            : advance by one pixel (output consumed)
//   o_col, o_row     : coordinate of the pixel currently presented
module px_coord_cnt
  import gray_conv_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               i_clk,
  input  logic               i_clear_n,
  input  logic               i_clr,
  input  logic               i_adv,
  output logic [COORD_W-1:0] o_col,
  output logic [COORD_W-1:0] o_row
);

  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;

  always_ff @(posedge i_clk) begin
    if (!i_clear_n || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (r_col == COORD_W'(IMG_W - 1)) begin
        r_col <= '0;
        // row wraps at frame end so the next frame starts at (0,0)
        r_row <= (r_row == COORD_W'(IMG_H - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;

endmodule

// File: rtl/gray_conv_ctrl.sv
// Frame controller for an RGB->gray datapath: pixel handshake, pipeline
// valid tracking, output register control and frame sequencing.
//   i_clk     : clock
//   i_clear_n : synchronous active-low reset (aborts any frame in flight)
//   bus       : handshake/status bundle (slave side), see gray_conv_ctrl_if
module gray_conv_ctrl
  import gray_conv_ctrl_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIPE_LAT = 3
) (
  input  logic             i_clk,
  input  logic             i_clear_n,
  gray_conv_ctrl_if.slave  bus
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);

  state_t              r_state;
  logic [PIPE_LAT-1:0] r_vld_pipe;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_frame_done;
  logic [CNT_W-1:0]    r_in_cnt;
  logic [CNT_W-1:0]    r_out_cnt;

  logic w_active, w_stall, w_pipe_en, w_pix_ready, w_accept;
  logic w_out_en, w_consume, w_last_in, w_last_out, w_run_entry;

  // A full output register with no taker freezes the whole pipe and input.
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_stall     = r_out_valid & ~bus.out_ready;
  assign w_pipe_en   = w_active & ~w_stall;
  assign w_pix_ready = (r_state == ST_RUN) & ~w_stall;
  assign w_accept    = bus.pix_valid & w_pix_ready;
  assign w_out_en    = w_pipe_en & r_vld_pipe[PIPE_LAT-1];
  assign w_consume   = r_out_valid & bus.out_ready;
  assign w_last_in   = w_accept  && (r_in_cnt  == CNT_W'(NPIX - 1));
  assign w_last_out  = w_consume && (r_out_cnt == CNT_W'(NPIX - 1));
  assign w_run_entry = (r_state == ST_IDLE) & bus.start;

  always_ff @(posedge i_clk) begin
    if (!i_clear_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
        end
        ST_RUN:   if (w_last_in) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_last_out) begin
          r_state      <= ST_DONE;
          r_frame_done <= 1'b1;
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Valid bits travel alongside the datapath; bubbles are shifted in as 0.
  always_ff @(posedge i_clk) begin
    if (!i_clear_n)     r_vld_pipe <= '0;
    else if (w_pipe_en) r_vld_pipe <= (r_vld_pipe << 1) | PIPE_LAT'(w_accept);
  end

  // Load wins over consume so back-to-back outputs keep out_valid high.
  always_ff @(posedge i_clk) begin
    if (!i_clear_n)     r_out_valid <= 1'b0;
    else if (w_out_en)  r_out_valid <= 1'b1;
    else if (w_consume) r_out_valid <= 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_clear_n || w_run_entry) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_accept)  r_in_cnt  <= r_in_cnt + 1'b1;
      if (w_consume) r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  px_coord_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_coord (
    .i_clk     (i_clk),
    .i_clear_n (i_clear_n),
    .i_clr     (w_run_entry),
    .i_adv     (w_consume),
    .o_col     (bus.col),
    .o_row     (bus.row)
  );

  assign bus.pix_ready  = w_pix_ready;
  assign bus.load_en    = w_accept;
  assign bus.pipe_en    = w_pipe_en;
  assign bus.out_en     = w_out_en;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_gray_conv_ctrl.sv
module tb_gray_conv_ctrl;
  localparam int W = 4, H = 2, L = 3, N = W * H;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  gray_conv_ctrl_if bif ();

  gray_conv_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(L)) dut (
    .i_clk     (clk),
    .i_clear_n (clr_n),
    .bus       (bif)
  );

  int total = 0, bad = 0, cyc = 0;

  // Transaction-level reference: pixel indices in flight, -1 marks a bubble.
  int phase, n_in, n_out, m_out;
  int slot [L];

  int f_loads, f_cons, f_done, first_load, last_load, first_ov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase = P_IDLE; n_in = 0; n_out = 0; m_out = -1;
    for (int i = 0; i < L; i++) slot[i] = -1;
  endtask

  task automatic run_cycle(input logic st, input logic pv, input logic ordy, input logic cn);
    bit e_stall, e_act, e_adv, e_acc, e_cons, e_oen;
    int nxt;
    bif.start = st; bif.pix_valid = pv; bif.out_ready = ordy; clr_n = cn;
    @(negedge clk);
    e_stall = (m_out >= 0) && !ordy;
    e_act   = (phase == P_RUN) || (phase == P_DRAIN);
    e_adv   = e_act && !e_stall;
    e_acc   = (phase == P_RUN) && !e_stall && pv;
    e_cons  = (m_out >= 0) && ordy;
    e_oen   = e_adv && (slot[L-1] >= 0);
    chk("pix_ready",  bif.pix_ready,  32'((phase == P_RUN) && !e_stall));
    chk("load_en",    bif.load_en,    32'(e_acc));
    chk("pipe_en",    bif.pipe_en,    32'(e_adv));
    chk("out_en",     bif.out_en,     32'(e_oen));
    chk("out_valid",  bif.out_valid,  32'(m_out >= 0));
    chk("col",        bif.col,        32'(n_out % W));
    chk("row",        bif.row,        32'((n_out / W) % H));
    chk("busy",       bif.busy,       32'(phase != P_IDLE));
    chk("frame_done", bif.frame_done, 32'(phase == P_DONE));
    if (bif.load_en === 1'b1) begin
      f_loads++; last_load = cyc;
      if (first_load < 0) first_load = cyc;
    end
    if (bif.out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
    if (bif.out_valid === 1'b1 && ordy) f_cons++;
    if (bif.frame_done === 1'b1) f_done++;
    // advance the reference by one clock
    if (!cn) model_reset();
    else begin
      nxt = e_cons ? -1 : m_out;
      if (e_adv) begin
        if (slot[L-1] >= 0) nxt = slot[L-1];
        for (int i = L - 1; i > 0; i--) slot[i] = slot[i-1];
        slot[0] = e_acc ? n_in : -1;
      end
      m_out = nxt;
      case (phase)
        P_IDLE:  if (st) begin phase = P_RUN; n_in = 0; n_out = 0; end
        P_RUN:   if (e_acc && n_in == N - 1) phase = P_DRAIN;
        P_DRAIN: if (e_cons && n_out == N - 1) phase = P_DONE;
        default: phase = P_IDLE;
      endcase
      if (e_acc)  n_in++;
      if (e_cons) n_out++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // mode 0: steady flow, 1: output stall, 2: toggling input, 3: random
  task automatic run_frame(input int mode);
    int  i;
    bit  seen_done;
    logic st, pv, ordy;
    f_loads = 0; f_cons = 0; f_done = 0;
    first_load = -1; last_load = -1; first_ov = -1;
    seen_done = 0;
    for (i = 0; i < 300; i++) begin
      st = (i == 0) || (mode == 0 && i < 4);
      pv = 1'b1; ordy = 1'b1;
      if (mode == 1) ordy = !(i >= 6 && i < 11);
      if (mode == 2) pv = (i % 2) == 1;
      if (mode == 3) begin
        pv   = 1'($urandom_range(0, 1));
        ordy = ($urandom_range(0, 3) != 0);
      end
      run_cycle(st, pv, ordy, 1'b1);
      if (phase == P_DONE) seen_done = 1;
      if (seen_done && phase == P_IDLE) break;
    end
    chk($sformatf("m%0d_no_timeout", mode), 32'(i < 300), 32'd1);
    chk($sformatf("m%0d_loads", mode), 32'(f_loads), 32'(N));
    chk($sformatf("m%0d_outputs", mode), 32'(f_cons), 32'(N));
    chk($sformatf("m%0d_frame_done", mode), 32'(f_done), 32'd1);
    if (mode == 0) begin
      chk("latency", 32'(first_ov - first_load), 32'(L + 1));
      chk("loads_back_to_back", 32'(last_load - first_load), 32'(N - 1));
    end
  endtask

  initial begin
    bif.start = 1'b0; bif.pix_valid = 1'b0; bif.out_ready = 1'b0;
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    // reset state, with Pix_Valid held in IDLE: no load, no state change
    repeat (3) run_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    run_frame(0);
    run_frame(1);
    run_frame(2);
    // abort with pixels in flight, then a clean frame
    run_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1);
    f_done = 0;
    run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) run_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("abort_no_frame_done", 32'(f_done), 32'd0);
    run_frame(0);
    repeat (3) run_frame(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
